// File: rtl/axi4_pkg.sv
// Shared AXI4 response/burst codes, FSM state types and address helpers
// for the single-port AXI4 memory slave.
package axi4_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base,
                                               input int unsigned shift);
        return (addr - base) >> shift;
    endfunction

    // Below base the subtraction wraps, so the lower bound is checked separately.
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned shift,
                                      input int unsigned depth);
        return (addr >= base) && (word_index(addr, base, shift) < depth);
    endfunction

endpackage

// File: rtl/axi4_slave_mem.sv
// Word storage with per-byte write enables and a registered, enable-gated read
// port; a read and write of the same word in one cycle returns the old data.
module axi4_slave_mem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned IDX_W  = 4
) (
    input  logic                clk_i,
    input  logic                we_i,
    input  logic [IDX_W-1:0]    waddr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    input  logic                re_i,
    input  logic [IDX_W-1:0]    raddr_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_i[b]) begin
                    mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4 INCR-burst memory slave: independent read and write channel FSMs sharing
// one storage block; out-of-range beats answer SLVERR.
module axi4_mem_slave
    import axi4_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter logic [31:0] BASE   = 32'h0
) (
    input  logic                aclk,
    input  logic                areset,

    input  logic                arvalid,
    output logic                arready,
    input  logic [31:0]         araddr,
    input  logic [7:0]          arlen,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,

    input  logic                awvalid,
    output logic                awready,
    input  logic [31:0]         awaddr,
    input  logic [7:0]          awlen,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned SHIFT  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] BYTES  = 32'(STRB_W);
    localparam logic [31:0] ALIGN  = ~(BYTES - 32'd1);

    // Holds the address-ready outputs low until the first clock after reset.
    logic init_q;

    rd_state_t   r_state_q, r_state_d;
    logic [31:0] r_addr_q, r_addr_d;
    logic [7:0]  r_len_q, r_len_d;
    logic [7:0]  r_cnt_q, r_cnt_d;
    logic        r_err_q, r_err_d;
    logic        r_fetch;
    logic        r_fetch_ok;
    logic [31:0] r_fetch_addr;

    wr_state_t   w_state_q, w_state_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [7:0]  w_len_q, w_len_d;
    logic [7:0]  w_cnt_q, w_cnt_d;
    logic        w_err_q, w_err_d;
    logic        w_beat_ok;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic              mem_re;
    logic [IDX_W-1:0]  mem_raddr;
    logic [DATA_W-1:0] mem_rdata;

    // Read channel: memory is fetched on the AR handshake and on each accepted
    // beat, so the registered output always holds the beat being presented.
    always_comb begin
        r_state_d    = r_state_q;
        r_addr_d     = r_addr_q;
        r_len_d      = r_len_q;
        r_cnt_d      = r_cnt_q;
        r_err_d      = r_err_q;
        r_fetch      = 1'b0;
        r_fetch_addr = r_addr_q + BYTES;

        unique case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready) begin
                    r_fetch      = 1'b1;
                    r_fetch_addr = araddr & ALIGN;
                    r_addr_d     = r_fetch_addr;
                    r_len_d      = arlen;
                    r_cnt_d      = 8'd0;
                    r_state_d    = R_DATA;
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (r_cnt_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_fetch  = 1'b1;
                        r_addr_d = r_fetch_addr;
                        r_cnt_d  = r_cnt_q + 8'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        r_fetch_ok = in_range(r_fetch_addr, BASE, SHIFT, DEPTH);
        if (r_fetch) begin
            r_err_d = !r_fetch_ok;
        end
        mem_re    = r_fetch && r_fetch_ok;
        mem_raddr = IDX_W'(word_index(r_fetch_addr, BASE, SHIFT));
    end

    assign arready = (r_state_q == R_IDLE) && init_q;
    assign rvalid  = (r_state_q == R_DATA);
    assign rlast   = rvalid && (r_cnt_q == r_len_q);
    assign rresp   = (rvalid && r_err_q) ? SLVERR : OKAY;
    assign rdata   = (rvalid && !r_err_q) ? mem_rdata : '0;

    // Write channel: the burst length, not wlast, decides when the burst ends;
    // a wlast disagreement only poisons the response.
    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        w_beat_ok = in_range(w_addr_q, BASE, SHIFT, DEPTH);
        mem_waddr = IDX_W'(word_index(w_addr_q, BASE, SHIFT));

        unique case (w_state_q)
            W_IDLE: begin
                if (awvalid && awready) begin
                    w_addr_d  = awaddr & ALIGN;
                    w_len_d   = awlen;
                    w_cnt_d   = 8'd0;
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    mem_we = w_beat_ok;
                    if (!w_beat_ok || (wlast != (w_cnt_q == w_len_q))) begin
                        w_err_d = 1'b1;
                    end
                    if (w_cnt_q == w_len_q) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d  = w_cnt_q + 8'd1;
                        w_addr_d = w_addr_q + BYTES;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign awready = (w_state_q == W_IDLE) && init_q;
    assign wready  = (w_state_q == W_DATA);
    assign bvalid  = (w_state_q == W_RESP);
    assign bresp   = (bvalid && w_err_q) ? SLVERR : OKAY;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            init_q    <= 1'b0;
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_err_q   <= 1'b0;
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
        end else begin
            init_q    <= 1'b1;
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_err_q   <= r_err_d;
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
        end
    end

    axi4_slave_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk_i   (aclk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (wdata),
        .wstrb_i (wstrb),
        .re_i    (mem_re),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed bench for axi4_mem_slave: single-beat vector table plus hand-written
// burst, stall, range, wlast, concurrency and reset sequences.
module tb_axi4_mem_slave;

    logic        aclk;
    logic        areset;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [1:0]  bresp;

    int n_vec = 0;
    int n_bad = 0;

    axi4_mem_slave dut (
        .aclk    (aclk),
        .areset  (areset),
        .arvalid (arvalid),
        .arready (arready),
        .araddr  (araddr),
        .arlen   (arlen),
        .rvalid  (rvalid),
        .rready  (rready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rlast   (rlast),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .awlen   (awlen),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wlast   (wlast),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL timeout waiting for %s", name);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] dat0, input logic [3:0] strb,
                            input int wlast_at, output logic [1:0] resp);
        int t;
        @(negedge aclk);
        awvalid = 1'b1;
        awaddr  = addr;
        awlen   = len;
        t = 0;
        while (!awready && t < 20) begin
            @(negedge aclk);
            t++;
        end
        if (!awready) timeout("awready");
        @(posedge aclk);
        #1;
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wvalid = 1'b1;
            wdata  = dat0 + 32'(b);
            wstrb  = strb;
            wlast  = (b == wlast_at);
            @(negedge aclk);
            t = 0;
            while (!wready && t < 20) begin
                @(negedge aclk);
                t++;
            end
            if (!wready) timeout("wready");
            @(posedge aclk);
            #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        bready = 1'b1;
        @(negedge aclk);
        t = 0;
        while (!bvalid && t < 20) begin
            @(negedge aclk);
            t++;
        end
        if (!bvalid) timeout("bvalid");
        resp = bresp;
        @(posedge aclk);
        #1;
        bready = 1'b0;
    endtask

    // Returns just after the AR handshake edge.
    task automatic start_read(input logic [31:0] addr, input logic [7:0] len);
        int t;
        @(negedge aclk);
        arvalid = 1'b1;
        araddr  = addr;
        arlen   = len;
        t = 0;
        while (!arready && t < 20) begin
            @(negedge aclk);
            t++;
        end
        if (!arready) timeout("arready");
        @(posedge aclk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output logic last);
        int t;
        start_read(addr, 8'd0);
        rready = 1'b1;
        @(negedge aclk);
        t = 0;
        while (!rvalid && t < 20) begin
            @(negedge aclk);
            t++;
        end
        if (!rvalid) timeout("rvalid");
        data = rdata;
        resp = rresp;
        last = rlast;
        @(posedge aclk);
        #1;
        rready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
        int          beat;

        vecs[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 32'h0,         2'b00};
        vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
        vecs[2]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b00};
        vecs[3]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 4'h3, 32'h0,         2'b00};
        vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'hFFFF_0000, 2'b00};
        vecs[5]  = '{1'b1, 32'h0000_003C, 32'h1234_5678, 4'hF, 32'h0,         2'b00};
        vecs[6]  = '{1'b0, 32'h0000_003C, 32'h0,         4'h0, 32'h1234_5678, 2'b00};
        vecs[7]  = '{1'b1, 32'h0000_0040, 32'hAAAA_AAAA, 4'hF, 32'h0,         2'b10};
        vecs[8]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'h0,         2'b10};
        vecs[9]  = '{1'b0, 32'h0000_000B, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00};
        vecs[10] = '{1'b1, 32'h0000_0004, 32'h1122_3344, 4'hF, 32'h0,         2'b00};
        vecs[11] = '{1'b1, 32'h0000_0006, 32'hAB00_0000, 4'h8, 32'h0,         2'b00};
        vecs[12] = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'hAB22_3344, 2'b00};
        vecs[13] = '{1'b1, 32'hFFFF_FFF0, 32'h0000_0055, 4'hF, 32'h0,         2'b10};
        vecs[14] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0,         2'b10};

        areset  = 1'b1;
        arvalid = 1'b0; araddr = '0; arlen = '0; rready = 1'b0;
        awvalid = 1'b0; awaddr = '0; awlen = '0;
        wvalid  = 1'b0; wdata  = '0; wstrb = '0; wlast  = 1'b0; bready = 1'b0;

        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("reset rvalid", 32'(rvalid), 32'd0);
        chk("reset bvalid", 32'(bvalid), 32'd0);
        chk("reset wready", 32'(wready), 32'd0);
        chk("reset rlast",  32'(rlast),  32'd0);
        chk("reset rdata",  rdata,       32'd0);
        chk("reset rresp",  32'(rresp),  32'd0);
        chk("reset bresp",  32'(bresp),  32'd0);
        areset = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        chk("post-reset arready", 32'(arready), 32'd1);
        chk("post-reset awready", 32'(awready), 32'd1);

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, 8'd0, vecs[i].data, vecs[i].strb, 0, r);
                chk($sformatf("vec%0d bresp", i), 32'(r), 32'(vecs[i].exp_resp));
            end else begin
                do_read(vecs[i].addr, d, r, l);
                chk($sformatf("vec%0d rdata", i), d, vecs[i].exp_data);
                chk($sformatf("vec%0d rresp", i), 32'(r), 32'(vecs[i].exp_resp));
                chk($sformatf("vec%0d rlast", i), 32'(l), 32'd1);
            end
        end

        // Burst write 1..4 then read back with rready toggling 1,0,1,0.
        do_write(32'h0, 8'd3, 32'd1, 4'hF, 3, r);
        chk("burst bresp", 32'(r), 32'd0);
        start_read(32'h0, 8'd3);
        beat = 0;
        for (int k = 0; k < 40 && beat < 4; k++) begin
            rready = (k % 2 == 0);
            @(negedge aclk);
            chk($sformatf("burst k%0d rvalid", k), 32'(rvalid), 32'd1);
            chk($sformatf("burst k%0d rdata", k), rdata, 32'(beat + 1));
            chk($sformatf("burst k%0d rlast", k), 32'(rlast), 32'(beat == 3));
            if (rready) beat++;
            @(posedge aclk);
            #1;
        end
        rready = 1'b0;
        chk("burst beats", 32'(beat), 32'd4);
        @(negedge aclk);
        chk("burst end rvalid", 32'(rvalid), 32'd0);

        // Read crossing the top of storage: second beat is out of range.
        start_read(32'h3C, 8'd1);
        rready = 1'b1;
        @(negedge aclk);
        chk("edge b0 rdata", rdata, 32'h1234_5678);
        chk("edge b0 rresp", 32'(rresp), 32'd0);
        chk("edge b0 rlast", 32'(rlast), 32'd0);
        @(posedge aclk);
        #1;
        @(negedge aclk);
        chk("edge b1 rvalid", 32'(rvalid), 32'd1);
        chk("edge b1 rdata", rdata, 32'd0);
        chk("edge b1 rresp", 32'(rresp), 32'd2);
        chk("edge b1 rlast", 32'(rlast), 32'd1);
        @(posedge aclk);
        #1;
        rready = 1'b0;

        // Early wlast: all three beats still land, response is SLVERR.
        do_write(32'h10, 8'd2, 32'h100, 4'hF, 1, r);
        chk("early wlast bresp", 32'(r), 32'd2);
        chk("early wlast wready", 32'(wready), 32'd0);
        start_read(32'h10, 8'd2);
        rready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge aclk);
            chk($sformatf("early wlast rd%0d", b), rdata, 32'h100 + 32'(b));
            chk($sformatf("early wlast rresp%0d", b), 32'(rresp), 32'd0);
            @(posedge aclk);
            #1;
        end
        rready = 1'b0;
        do_write(32'h20, 8'd1, 32'h200, 4'hF, 99, r);
        chk("missing wlast bresp", 32'(r), 32'd2);

        // Same-cycle read and write of word 5 must return the old value.
        @(negedge aclk);
        awvalid = 1'b1; awaddr = 32'h14; awlen = 8'd0;
        @(posedge aclk);
        #1;
        awvalid = 1'b0;
        wvalid = 1'b1; wdata = 32'hBEEF_0000; wstrb = 4'hF; wlast = 1'b1;
        arvalid = 1'b1; araddr = 32'h14; arlen = 8'd0;
        @(negedge aclk);
        chk("collide wready", 32'(wready), 32'd1);
        chk("collide arready", 32'(arready), 32'd1);
        @(posedge aclk);
        #1;
        wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0; rready = 1'b1; bready = 1'b1;
        @(negedge aclk);
        chk("collide rdata", rdata, 32'h101);
        chk("collide bvalid", 32'(bvalid), 32'd1);
        @(posedge aclk);
        #1;
        rready = 1'b0; bready = 1'b0;
        do_read(32'h14, d, r, l);
        chk("collide reread", d, 32'hBEEF_0000);

        // Asynchronous reset while beat 2 of 4 is presented.
        start_read(32'h0, 8'd3);
        rready = 1'b1;
        repeat (2) begin
            @(posedge aclk);
            #1;
        end
        #2;
        areset = 1'b1;
        #1;
        chk("async reset rvalid", 32'(rvalid), 32'd0);
        rready = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        chk("after reset arready", 32'(arready), 32'd1);
        do_write(32'h8, 8'd0, 32'hCAFE_F00D, 4'hF, 0, r);
        chk("after reset bresp", 32'(r), 32'd0);
        do_read(32'h8, d, r, l);
        chk("after reset rdata", d, 32'hCAFE_F00D);
        chk("after reset rlast", 32'(l), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/axi4_mem_slave.md
AXI4_MEM_SLAVE -- requirements
Module: axi4_mem_slave

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, number of DATA_W words of storage.
REQ-003 SHALL have parameter BASE, default 32'h0, byte address of word 0.
REQ-004 aclk  in  1  single clock; all logic on rising edge.
REQ-005 areset  in  1  asynchronous, active-high reset.
REQ-006 arvalid/arready  in/out  1/1  read-address handshake.
REQ-007 araddr, arlen  in  32, 8  start byte address, beats-1.
REQ-008 rvalid/rready  out/in  1/1  read-data handshake.
REQ-009 rdata, rresp, rlast  out  DATA_W, 2, 1  read beat, response, last beat.
REQ-010 awvalid/awready  in/out  1/1  write-address handshake.
REQ-011 awaddr, awlen  in  32, 8  start byte address, beats-1.
REQ-012 wvalid/wready  in/out  1/1  write-data handshake.
REQ-013 wdata, wstrb, wlast  in  DATA_W, DATA_W/8, 1  write beat, byte enables, last flag.
REQ-014 bvalid/bready  out/in  1/1  write-response handshake.
REQ-015 bresp  out  2  write response.

Function
REQ-016 Bursts SHALL be INCR only, word-aligned; the low log2(DATA_W/8) address bits SHALL be ignored; word index = (addr-BASE)>>log2(DATA_W/8), incremented by 1 per beat.
REQ-017 Read FSM states SHALL be R_IDLE, R_DATA: R_IDLE asserts arready; on arvalid&&arready latch address and length and go to R_DATA; in R_DATA rvalid=1; each rvalid&&rready advances the beat; the beat with count==arlen asserts rlast and returns to R_IDLE.
REQ-018 First rvalid SHALL assert exactly 1 cycle after the AR handshake; back-to-back beats SHALL issue every cycle while rready=1.
REQ-019 rdata/rresp/rlast SHALL hold stable while rvalid=1 and rready=0.
REQ-020 Write FSM states SHALL be W_IDLE, W_DATA, W_RESP: W_IDLE asserts awready; AW handshake goes to W_DATA; W_DATA asserts wready, writes each accepted beat with byte lanes selected by wstrb; the beat with count==awlen goes to W_RESP; W_RESP asserts bvalid until bready, then W_IDLE.
REQ-021 wlast mismatch (wlast=1 early or 0 on final beat) SHALL set bresp=SLVERR for that burst; the burst SHALL still terminate on beat count==awlen.
REQ-022 Any beat whose word index >= DEPTH or whose address < BASE SHALL be out of range: reads return rdata=0, rresp=SLVERR; writes are dropped and bresp=SLVERR; otherwise OKAY.
REQ-023 Read and write channels SHALL operate concurrently; a same-cycle read and write of one word SHALL return the pre-write data.
REQ-024 A word index passing DEPTH-1 mid-burst SHALL not wrap; remaining beats are out of range.
REQ-025 arready SHALL be 0 outside R_IDLE; awready SHALL be 0 outside W_IDLE; wready SHALL be 0 outside W_DATA.

Reset
REQ-026 On areset, both FSMs SHALL go to IDLE asynchronously; rvalid, bvalid, wready, rlast=0; arready, awready=1 after the first clock with areset=0; rdata=0, rresp=bresp=OKAY.
REQ-027 Reset mid-burst SHALL abandon the burst without a response; storage contents SHALL be undefined after reset and SHALL NOT be cleared.

Structure
REQ-028 Package axi4_pkg SHALL hold resp codes (OKAY=2'b00, SLVERR=2'b10), burst type codes, and the read/write FSM state enums.
REQ-029 Storage SHALL be a sub-module axi4_slave_mem: one write port with byte enables, one read port, registered read.

Verification
REQ-030 Single write awaddr=0x8, awlen=0, wdata=0xDEADBEEF, wstrb=0xF, then read araddr=0x8 -> bresp=OKAY, rdata=0xDEADBEEF, rlast=1.
REQ-031 Burst write awaddr=0x0, awlen=3, data 1..4, then read burst arlen=3 with rready toggling 1,0,1,0 -> rdata 1,2,3,4 each held while stalled, rlast only on the 4th beat.
REQ-032 Partial strobe: word 0x0=0xFFFFFFFF, write 0x00000000 with wstrb=0x3 -> read 0xFFFF0000.
REQ-033 Read araddr=0x3C, arlen=1 with DEPTH=16 -> beat 0 OKAY with stored data, beat 1 rdata=0, rresp=SLVERR.
REQ-034 Write awlen=2 with wlast=1 on beat 1 -> three beats accepted, bresp=SLVERR.
REQ-035 areset asserted during R_DATA beat 2 of 4 -> rvalid=0 immediately; after release a new read completes normally.
